cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 136 +++++++++++++
 tb/tb_cache_controller.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Direct-mapped cache controller: sequences tag compare, dirty writeback and
// line fill against a registered data array and a line-wide backing memory.
module cache_controller #(
    parameter int unsigned s_offset = 5,
    parameter int unsigned s_index  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [31:0]              mem_address,
    input  logic [2**s_offset-1:0]   mem_byte_enable,
    output logic                     mem_resp,
    output logic                     array_read,
    output logic [2**s_offset-1:0]   array_write_en,
    output logic [s_index-1:0]       array_index,
    output logic                     array_datain_sel,
    output logic                     pmem_read,
    output logic                     pmem_write,
    output logic [31:0]              pmem_address,
    input  logic                     pmem_resp
);

    localparam int unsigned num_sets = 2 ** s_index;
    localparam int unsigned tag_w    = 32 - s_index - s_offset;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, FILL, RELOAD} state_t;

    state_t              state;
    logic [tag_w-1:0]    tags [num_sets];
    logic [num_sets-1:0] valid;
    logic [num_sets-1:0] dirty;
    logic [tag_w-1:0]    req_tag;
    logic [s_index-1:0]  req_idx;
    logic                req_write;

    logic [tag_w-1:0]    addr_tag;
    logic [s_index-1:0]  addr_idx;
    logic                hit;
    logic                fill_done;
    logic                unused_offset_bits;

    assign addr_tag           = mem_address[31 -: tag_w];
    assign addr_idx           = mem_address[s_offset +: s_index];
    assign hit                = valid[req_idx] && (tags[req_idx] == req_tag);
    assign fill_done          = (state == FILL) && pmem_read && pmem_resp;
    assign unused_offset_bits = ^mem_address[s_offset-1:0];

    // Tags need no reset: valid bits gate every use.
    always_ff @(posedge clk) begin
        if (fill_done)
            tags[req_idx] <= req_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            valid            <= '0;
            dirty            <= '0;
            req_tag          <= '0;
            req_idx          <= '0;
            req_write        <= 1'b0;
            mem_resp         <= 1'b0;
            array_read       <= 1'b0;
            array_write_en   <= '0;
            array_index      <= '0;
            array_datain_sel <= 1'b0;
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            pmem_address     <= '0;
        end else begin
            mem_resp         <= 1'b0;
            array_read       <= 1'b0;
            array_write_en   <= '0;
            array_datain_sel <= 1'b0;
            case (state)
                // mem_resp high means the CPU is still holding the finished request.
                IDLE: begin
                    if ((mem_read || mem_write) && !mem_resp) begin
                        req_tag     <= addr_tag;
                        req_idx     <= addr_idx;
                        req_write   <= mem_write;
                        array_index <= addr_idx;
                        array_read  <= 1'b1;
                        state       <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        mem_resp <= 1'b1;
                        if (req_write) begin
                            array_write_en   <= mem_byte_enable;
                            dirty[req_idx]   <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (valid[req_idx] && dirty[req_idx]) begin
                        pmem_write   <= 1'b1;
                        pmem_address <= {tags[req_idx], req_idx, {s_offset{1'b0}}};
                        state        <= WRITEBACK;
                    end else begin
                        pmem_read    <= 1'b1;
                        pmem_address <= {req_tag, req_idx, {s_offset{1'b0}}};
                        state        <= FILL;
                    end
                end
                // One idle bus cycle separates the writeback from the fill.
                WRITEBACK: begin
                    if (pmem_resp) begin
                        pmem_write   <= 1'b0;
                        pmem_address <= {req_tag, req_idx, {s_offset{1'b0}}};
                        state        <= FILL;
                    end
                end
                FILL: begin
                    if (!pmem_read) begin
                        pmem_read <= 1'b1;
                    end else if (pmem_resp) begin
                        pmem_read        <= 1'b0;
                        pmem_address     <= '0;
                        array_write_en   <= '1;
                        array_datain_sel <= 1'b1;
                        valid[req_idx]   <= 1'b1;
                        dirty[req_idx]   <= 1'b0;
                        state            <= RELOAD;
                    end
                end
                RELOAD: begin
                    array_read <= 1'b1;
                    state      <= COMPARE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: a memory responder plus a queue of
// expected bus events, write enables and response latencies.
module tb_cache_controller;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_byte_enable;
    logic        mem_resp;
    logic        array_read;
    logic [31:0] array_write_en;
    logic [2:0]  array_index;
    logic        array_datain_sel;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic        pmem_resp;

    cache_controller dut (
        .clk              (clk),
        .rst              (rst),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_address      (mem_address),
        .mem_byte_enable  (mem_byte_enable),
        .mem_resp         (mem_resp),
        .array_read       (array_read),
        .array_write_en   (array_write_en),
        .array_index      (array_index),
        .array_datain_sel (array_datain_sel),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_address     (pmem_address),
        .pmem_resp        (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum logic [2:0] {EV_NONE, EV_WB, EV_FILL, EV_WEN_CPU, EV_WEN_MEM, EV_RESP} ev_t;
    typedef struct packed {
        ev_t         kind;
        logic [31:0] val;
    } ev_s;

    ev_s sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input ev_t kind, input logic [31:0] val);
        ev_s e;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag, input ev_t kind, input logic [31:0] val);
        ev_s e;
        e.kind = EV_NONE;
        e.val  = '0;
        if (sb.size() != 0) e = sb.pop_front();
        check({tag, " kind"}, 64'(kind), 64'(e.kind));
        check({tag, " value"}, 64'(val), 64'(e.val));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_resp"}, 64'(mem_resp), 64'(0));
        check({tag, " array_read"}, 64'(array_read), 64'(0));
        check({tag, " array_write_en"}, 64'(array_write_en), 64'(0));
        check({tag, " array_datain_sel"}, 64'(array_datain_sel), 64'(0));
        check({tag, " pmem_read"}, 64'(pmem_read), 64'(0));
        check({tag, " pmem_write"}, 64'(pmem_write), 64'(0));
        check({tag, " pmem_address"}, 64'(pmem_address), 64'(0));
    endtask

    // Drives one request from a negedge and acts as memory until mem_resp;
    // *_hold is how many cycles the strobe stays up, resp in the last one.
    task automatic run_req(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [31:0] be, input logic [2:0] exp_idx,
                           input int wb_hold, input int fill_hold);
        int cnt = 0;
        int wbc = 0;
        int flc = 0;
        int wen_cnt = -1;
        bit done = 1'b0;
        mem_read        = !wr;
        mem_write       = wr;
        mem_address     = addr;
        mem_byte_enable = be;
        while (!done && cnt < 100) begin
            @(negedge clk);
            cnt++;
            pmem_resp = 1'b0;
            if (pmem_read && pmem_write)
                check({tag, " pmem exclusive"}, 64'(1), 64'(0));
            if (array_read)
                check({tag, " array_index"}, 64'(array_index), 64'(exp_idx));
            if (pmem_write) begin
                wbc++;
                if (wbc == 1) pop_check({tag, " writeback"}, EV_WB, pmem_address);
                if (wbc == wb_hold) pmem_resp = 1'b1;
            end
            if (pmem_read) begin
                flc++;
                if (flc == 1) pop_check({tag, " fill"}, EV_FILL, pmem_address);
                if (flc == fill_hold) pmem_resp = 1'b1;
            end
            if (array_write_en != '0) begin
                if (array_datain_sel) begin
                    wen_cnt = cnt;
                    pop_check({tag, " fill write"}, EV_WEN_MEM, array_write_en);
                end else begin
                    pop_check({tag, " cpu write"}, EV_WEN_CPU, array_write_en);
                end
            end
            if (mem_resp) begin
                pop_check({tag, " latency"}, EV_RESP, 32'(cnt));
                if (wen_cnt >= 0)
                    check({tag, " fill-to-resp"}, 64'(cnt - wen_cnt), 64'(2));
                mem_read  = 1'b0;
                mem_write = 1'b0;
                done      = 1'b1;
            end
        end
        check({tag, " completed"}, 64'(done), 64'(1));
        check({tag, " queue drained"}, 64'(sb.size()), 64'(0));
        sb.delete();
        pmem_resp = 1'b0;
        @(negedge clk);
        check({tag, " resp single cycle"}, 64'(mem_resp), 64'(0));
    endtask

    initial begin
        rst             = 1'b1;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_byte_enable = '0;
        pmem_resp       = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset array_index", 64'(array_index), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // Stray memory response in IDLE is ignored.
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        check_all_zero("idle pmem_resp");
        check("idle pmem_resp state", 64'(int'(dut.state)), 64'(0));
        @(negedge clk);
        check_all_zero("idle pmem_resp later");

        // Cold read: clean miss, fill held 3 cycles -> 3 + 4.
        expect_ev(EV_FILL, 32'h0000_0040);
        expect_ev(EV_WEN_MEM, 32'hFFFF_FFFF);
        expect_ev(EV_RESP, 32'd7);
        run_req("cold read", 1'b0, 32'h0000_0040, 32'h0, 3'd2, 0, 3);

        expect_ev(EV_RESP, 32'd2);
        run_req("read hit", 1'b0, 32'h0000_0040, 32'h0, 3'd2, 0, 0);

        expect_ev(EV_WEN_CPU, 32'h0000_00F0);
        expect_ev(EV_RESP, 32'd2);
        run_req("write hit", 1'b1, 32'h0000_0044, 32'h0000_00F0, 3'd2, 0, 0);
        check("write hit dirty[2]", 64'(dut.dirty[2]), 64'(1));

        // Dirty conflict miss: wb held 2 + 1 turnaround + fill held 1 + 4.
        expect_ev(EV_WB, 32'h0000_0040);
        expect_ev(EV_FILL, 32'h0001_0040);
        expect_ev(EV_WEN_MEM, 32'hFFFF_FFFF);
        expect_ev(EV_RESP, 32'd8);
        run_req("dirty miss", 1'b0, 32'h0001_0040, 32'h0, 3'd2, 2, 1);
        check("dirty miss dirty[2]", 64'(dut.dirty[2]), 64'(0));
        check("dirty miss valid[2]", 64'(dut.valid[2]), 64'(1));

        // Reset while filling: set 2 is clean now, so this goes straight to FILL.
        mem_read    = 1'b1;
        mem_address = 32'h0000_0040;
        repeat (2) @(negedge clk);
        check("abort pmem_read up", 64'(pmem_read), 64'(1));
        check("abort pmem_write", 64'(pmem_write), 64'(0));
        check("abort pmem_address", 64'(pmem_address), 64'(32'h0000_0040));
        #2 rst = 1'b1;
        #1;
        check("abort pmem_read async drop", 64'(pmem_read), 64'(0));
        check("abort state", 64'(int'(dut.state)), 64'(0));
        mem_read = 1'b0;
        @(negedge clk);
        check_all_zero("abort in reset");
        rst = 1'b0;
        @(negedge clk);
        check("abort no resp", 64'(mem_resp), 64'(0));

        expect_ev(EV_FILL, 32'h0001_0040);
        expect_ev(EV_WEN_MEM, 32'hFFFF_FFFF);
        expect_ev(EV_RESP, 32'd6);
        run_req("post-reset read", 1'b0, 32'h0001_0040, 32'h0, 3'd2, 0, 2);

        // Write miss to set 4: fill, then the reload compare performs the write.
        expect_ev(EV_FILL, 32'h0000_0F80);
        expect_ev(EV_WEN_MEM, 32'hFFFF_FFFF);
        expect_ev(EV_WEN_CPU, 32'h0000_F000);
        expect_ev(EV_RESP, 32'd5);
        run_req("write miss", 1'b1, 32'h0000_0F8C, 32'h0000_F000, 3'd4, 0, 1);

        expect_ev(EV_RESP, 32'd2);
        run_req("set4 read hit", 1'b0, 32'h0000_0F80, 32'h0, 3'd4, 0, 0);

        expect_ev(EV_WB, 32'h0000_0F80);
        expect_ev(EV_FILL, 32'h0000_1F80);
        expect_ev(EV_WEN_MEM, 32'hFFFF_FFFF);
        expect_ev(EV_RESP, 32'd7);
        run_req("set4 evict", 1'b0, 32'h0000_1F9C, 32'h0, 3'd4, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
